// File: rtl/hvsync_generator.sv
// hvsync_generator: free-running VGA raster timing generator (640x480@60 by default).
// Ports:
//   clk        in   pixel clock, all state changes on rising edge
//   reset      in   synchronous active-high reset
//   hsync      out  horizontal sync, active-low, registered (lags hpos by one clock)
//   vsync      out  vertical sync, active-low, registered (lags vpos by one clock)
//   display_on out  combinational: beam is inside the visible area
//   hpos       out  current pixel column, 0..H_MAX
//   vpos       out  current line, 0..V_MAX
module hvsync_generator #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_TOP     = 33,
    parameter int unsigned V_BOTTOM  = 10,
    parameter int unsigned V_SYNC    = 2
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos
);

    localparam int unsigned CNT_W        = 10;
    localparam int unsigned H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int unsigned H_MAX        = H_DISPLAY + H_BACK + H_FRONT + H_SYNC - 1;
    localparam int unsigned V_SYNC_START = V_DISPLAY + V_BOTTOM;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;
    localparam int unsigned V_MAX        = V_DISPLAY + V_TOP + V_BOTTOM + V_SYNC - 1;

    localparam logic [CNT_W-1:0] H_MAX_C   = CNT_W'(H_MAX);
    localparam logic [CNT_W-1:0] V_MAX_C   = CNT_W'(V_MAX);
    localparam logic [CNT_W-1:0] H_SS_C    = CNT_W'(H_SYNC_START);
    localparam logic [CNT_W-1:0] H_SE_C    = CNT_W'(H_SYNC_END);
    localparam logic [CNT_W-1:0] V_SS_C    = CNT_W'(V_SYNC_START);
    localparam logic [CNT_W-1:0] V_SE_C    = CNT_W'(V_SYNC_END);
    localparam logic [CNT_W-1:0] H_DISP_C  = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] V_DISP_C  = CNT_W'(V_DISPLAY);

    logic [CNT_W-1:0] hpos_q, hpos_d;
    logic [CNT_W-1:0] vpos_q, vpos_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             hmaxxed;

    // Next-state: counters wrap at their maxima; syncs decode the pre-edge counters.
    always_comb begin
        hpos_d  = hpos_q;
        vpos_d  = vpos_q;
        hsync_d = 1'b1;
        vsync_d = 1'b1;
        hmaxxed = (hpos_q == H_MAX_C);

        if (hmaxxed) begin
            hpos_d = '0;
            if (vpos_q == V_MAX_C) begin
                vpos_d = '0;
            end else begin
                vpos_d = vpos_q + CNT_W'(1);
            end
        end else begin
            hpos_d = hpos_q + CNT_W'(1);
        end

        hsync_d = !((hpos_q >= H_SS_C) && (hpos_q <= H_SE_C));
        vsync_d = !((vpos_q >= V_SS_C) && (vpos_q <= V_SE_C));
    end

    // State register; reset dominates counting at any point of the frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            hpos_q  <= '0;
            vpos_q  <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign hpos       = hpos_q;
    assign vpos       = vpos_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    // Unregistered so it lines up with hpos/vpos in the same cycle.
    assign display_on = (hpos_q < H_DISP_C) && (vpos_q < V_DISP_C);

endmodule

// File: tb/tb_hvsync_generator.sv
// Bench for hvsync_generator: one full-size instance (line-level checks) and one
// shrunken-raster instance so whole frames fit in a short run.
module tb_hvsync_generator;

    // Shrunken raster for instance B: 32 clocks x 19 lines = 608 clocks per frame.
    localparam int HD_B = 20, HB_B = 4, HF_B = 3, HS_B = 5;
    localparam int VD_B = 12, VT_B = 3, VBOT_B = 2, VS_B = 2;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic       rst_a, rst_b;
    logic       hsync_a, vsync_a, don_a;
    logic [9:0] hpos_a, vpos_a;
    logic       hsync_b, vsync_b, don_b;
    logic [9:0] hpos_b, vpos_b;

    int errors = 0;
    int checks = 0;

    hvsync_generator dut_a (
        .clk(clk), .reset(rst_a), .hsync(hsync_a), .vsync(vsync_a),
        .display_on(don_a), .hpos(hpos_a), .vpos(vpos_a)
    );

    hvsync_generator #(
        .H_DISPLAY(HD_B), .H_BACK(HB_B), .H_FRONT(HF_B), .H_SYNC(HS_B),
        .V_DISPLAY(VD_B), .V_TOP(VT_B), .V_BOTTOM(VBOT_B), .V_SYNC(VS_B)
    ) dut_b (
        .clk(clk), .reset(rst_b), .hsync(hsync_b), .vsync(vsync_b),
        .display_on(don_b), .hpos(hpos_b), .vpos(vpos_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Raster model: everything follows from the clock count t since reset release.
    function automatic logic [13:0] model(input int t, input int hd, input int hb, input int hf,
                                          input int hs, input int vd, input int vt,
                                          input int vb, input int vs);
        int ht, vtot, h, v, ph, pv;
        logic e_hs, e_vs, e_don;
        ht   = hd + hb + hf + hs;
        vtot = vd + vt + vb + vs;
        h    = t % ht;
        v    = (t / ht) % vtot;
        e_don = (h < hd) && (v < vd);
        if (t == 0) begin
            e_hs = 1'b1;
            e_vs = 1'b1;
        end else begin
            ph   = (t - 1) % ht;
            pv   = ((t - 1) / ht) % vtot;
            e_hs = !(ph >= hd + hf && ph <= hd + hf + hs - 1);
            e_vs = !(pv >= vd + vb && pv <= vd + vb + vs - 1);
        end
        // {hsync, vsync, display_on, hpos[4:0]... } packed as h(10) is too wide; split below
        model = {e_hs, e_vs, e_don, 11'(0)};
    endfunction

    logic rsa_q = 1'b0, rsb_q = 1'b0;
    always @(posedge clk) begin
        rsa_q = rst_a;
        rsb_q = rst_b;
    end

    // Per-cycle compare of both instances against the model.
    int  ta = 0, tb = 0;
    bit  va = 1'b0, vb = 1'b0;
    always @(negedge clk) begin
        logic [13:0] m;
        if (rsa_q) begin ta = 0; va = 1'b1; end else if (va) ta++;
        if (rsb_q) begin tb = 0; vb = 1'b1; end else if (vb) tb++;
        if (va) begin
            m = model(ta, 640, 48, 16, 96, 480, 33, 10, 2);
            chk("a_hpos", 32'(hpos_a), 32'(ta % 800));
            chk("a_vpos", 32'(vpos_a), 32'((ta / 800) % 525));
            chk("a_hsync", 32'(hsync_a), 32'(m[13]));
            chk("a_vsync", 32'(vsync_a), 32'(m[12]));
            chk("a_display_on", 32'(don_a), 32'(m[11]));
        end
        if (vb) begin
            m = model(tb, HD_B, HB_B, HF_B, HS_B, VD_B, VT_B, VBOT_B, VS_B);
            chk("b_hpos", 32'(hpos_b), 32'(tb % 32));
            chk("b_vpos", 32'(vpos_b), 32'((tb / 32) % 19));
            chk("b_hsync", 32'(hsync_b), 32'(m[13]));
            chk("b_vsync", 32'(vsync_b), 32'(m[12]));
            chk("b_display_on", 32'(don_b), 32'(m[11]));
        end
    end

    initial begin
        int lowcnt, first_low, last_low, doff;
        int c, fall_c, rise_n, first_rise, last_rise, interval, run, lowrun, don_cnt, wraps;
        logic prev_vs;
        logic [9:0] prev_h, prev_v;

        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Reset state, full-size raster.
        chk("rst_hpos", 32'(hpos_a), 0);
        chk("rst_vpos", 32'(vpos_a), 0);
        chk("rst_hsync", 32'(hsync_a), 1);
        chk("rst_vsync", 32'(vsync_a), 1);
        chk("rst_display_on", 32'(don_a), 1);
        @(negedge clk);
        chk("first_count_hpos", 32'(hpos_a), 1);

        // Line wrap.
        for (int i = 0; i < 1000 && hpos_a != 10'd799; i++) @(negedge clk);
        chk("wait_h799", 32'(hpos_a), 799);
        chk("h799_vpos", 32'(vpos_a), 0);
        chk("h799_display_off", 32'(don_a), 0);
        @(negedge clk);
        chk("wrap_hpos", 32'(hpos_a), 0);
        chk("wrap_vpos", 32'(vpos_a), 1);

        // One full line of hsync / display_on observation.
        lowcnt = 0; first_low = -1; last_low = -1; doff = 0;
        for (int i = 0; i < 800; i++) begin
            if (hsync_a === 1'b0) begin
                lowcnt++;
                if (first_low < 0) first_low = int'(hpos_a);
                last_low = int'(hpos_a);
            end
            if (don_a === 1'b0) doff++;
            @(negedge clk);
        end
        chk("hsync_low_clocks", 32'(lowcnt), 96);
        chk("hsync_first_low_hpos", 32'(first_low), 657);
        chk("hsync_last_low_hpos", 32'(last_low), 752);
        chk("line_display_off_clocks", 32'(doff), 160);
        chk("after_line_vpos", 32'(vpos_a), 2);

        // Mid-line reset while hsync is low.
        for (int i = 0; i < 1000 && hpos_a != 10'd700; i++) @(negedge clk);
        chk("pre_reset_hsync_low", 32'(hsync_a), 0);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        chk("midrst_hpos", 32'(hpos_a), 0);
        chk("midrst_vpos", 32'(vpos_a), 0);
        chk("midrst_hsync", 32'(hsync_a), 1);
        chk("midrst_vsync", 32'(vsync_a), 1);
        @(negedge clk);
        chk("midrst_resume_hpos", 32'(hpos_a), 1);

        // Shrunken raster: three whole frames.
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        fall_c = -1; rise_n = 0; first_rise = -1; last_rise = -1; interval = -1;
        run = 0; lowrun = -1; don_cnt = 0; wraps = 0;
        prev_vs = vsync_b; prev_h = hpos_b; prev_v = vpos_b;
        for (c = 0; c < 3 * 608; c++) begin
            if (c > 0) begin
                if (prev_vs === 1'b1 && vsync_b === 1'b0 && fall_c < 0) fall_c = c;
                if (prev_vs === 1'b0 && vsync_b === 1'b1) begin
                    rise_n++;
                    if (first_rise < 0) first_rise = c;
                    if (last_rise >= 0) interval = c - last_rise;
                    last_rise = c;
                    lowrun = run;
                end
                if (prev_h == 10'd31 && prev_v == 10'd18 && hpos_b == 10'd0 && vpos_b == 10'd0)
                    wraps++;
            end
            if (vsync_b === 1'b0) run++; else run = 0;
            if (c < 608 && don_b === 1'b1) don_cnt++;
            prev_vs = vsync_b; prev_h = hpos_b; prev_v = vpos_b;
            @(negedge clk);
        end
        chk("b_vsync_first_fall", 32'(fall_c), 449);
        chk("b_vsync_first_rise", 32'(first_rise), 513);
        chk("b_vsync_rises", 32'(rise_n), 3);
        chk("b_vsync_rise_interval", 32'(interval), 608);
        chk("b_vsync_low_run", 32'(lowrun), 64);
        chk("b_display_on_clocks", 32'(don_cnt), 240);
        chk("b_frame_wraps", 32'(wraps), 2);

        // Mid-frame reset while vsync is low.
        for (int i = 0; i < 700 && !(vpos_b == 10'd14 && hpos_b == 10'd10); i++) @(negedge clk);
        chk("b_wait_v14_h10", 32'({vpos_b, hpos_b}), 32'({10'd14, 10'd10}));
        chk("b_pre_reset_vsync_low", 32'(vsync_b), 0);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        chk("b_midrst_hpos", 32'(hpos_b), 0);
        chk("b_midrst_vpos", 32'(vpos_b), 0);
        chk("b_midrst_hsync", 32'(hsync_b), 1);
        chk("b_midrst_vsync", 32'(vsync_b), 1);
        @(negedge clk);
        chk("b_midrst_resume_hpos", 32'(hpos_b), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
